// File: rtl/if_dual_fetch_pkg.sv
// Shared types for the dual-issue fetch stage.
// Opcode constants, slot classes and FSM encoding.
package if_dual_fetch_pkg;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_JAL   = 6'd3;

    typedef enum logic [1:0] {
        CLS_NONE,
        CLS_I,
        CLS_J,
        CLS_R
    } cls_t;

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_FAULT
    } state_t;

endpackage

// File: rtl/if_dual_fetch_if.sv
// Instruction memory port of the fetch stage.
// Two consecutive words are returned per cycle.
interface if_dual_fetch_if;

    logic [31:0] imem_addr;
    logic [31:0] imem_rdata0;
    logic [31:0] imem_rdata1;
    logic        imem_valid;

    modport master (
        output imem_addr,
        input  imem_rdata0,
        input  imem_rdata1,
        input  imem_valid
    );

    modport slave (
        input  imem_addr,
        output imem_rdata0,
        output imem_rdata1,
        output imem_valid
    );

endinterface

// File: rtl/if_dual_fetch_instr_classify.sv
// Maps one instruction word onto its issue-slot class.
// The all-zero word is a NOP and takes no slot.
module instr_classify
    import if_dual_fetch_pkg::*;
(
    input  logic [31:0] word,
    output cls_t        cls
);

    always_comb begin
        cls = CLS_I;
        if (word == 32'h0) begin
            cls = CLS_NONE;
        end else if (word[31:26] == OP_RTYPE) begin
            cls = CLS_R;
        end else if (word[31:26] == OP_J || word[31:26] == OP_JAL) begin
            cls = CLS_J;
        end
    end

endmodule

// File: rtl/if_dual_fetch.sv
// Dual-issue fetch stage: owns the PC, steers two words per cycle
// into the I/J/R slots and tracks issue statistics.
module if_dual_fetch
    import if_dual_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic              clk,
    input  logic              btnc_i,
    input  logic              hazard,
    input  logic              PCSrc,
    input  logic [31:0]       branch_target,
    input  logic              jump,
    input  logic [31:0]       jump_target,
    if_dual_fetch_if.master   imem,
    output logic              type_i,
    output logic              type_j,
    output logic              type_r,
    output logic [31:0]       instruction_i,
    output logic [31:0]       instruction_j,
    output logic [31:0]       instruction_r,
    output logic [31:0]       program_counter,
    output logic              fetch_fault,
    output logic [CNT_W-1:0]  issue_cnt,
    output logic [CNT_W-1:0]  dual_cnt
);

    state_t           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic             fault_q, fault_d;
    logic [CNT_W-1:0] issue_q, issue_d;
    logic [CNT_W-1:0] dual_q, dual_d;

    cls_t        c0, c1;
    logic        take0, take1;
    logic [1:0]  n_iss;
    logic [CNT_W:0] isum, dsum;

    instr_classify u_cls0 (.word(imem.imem_rdata0), .cls(c0));
    instr_classify u_cls1 (.word(imem.imem_rdata1), .cls(c1));

    always_ff @(posedge clk) begin
        if (!btnc_i) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            fault_q <= 1'b0;
            issue_q <= '0;
            dual_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            fault_q <= fault_d;
            issue_q <= issue_d;
            dual_q  <= dual_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        fault_d = fault_q;
        issue_d = issue_q;
        dual_d  = dual_q;
        take0   = 1'b0;
        take1   = 1'b0;
        n_iss   = 2'd0;
        isum    = '0;
        dsum    = '0;
        unique case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN: begin
                if (PCSrc) begin
                    if (branch_target[1:0] != 2'b00) begin
                        state_d = ST_FAULT;
                        fault_d = 1'b1;
                    end else begin
                        pc_d = branch_target;
                    end
                end else if (jump) begin
                    if (jump_target[1:0] != 2'b00) begin
                        state_d = ST_FAULT;
                        fault_d = 1'b1;
                    end else begin
                        pc_d = jump_target;
                    end
                end else if (!hazard && imem.imem_valid) begin
                    // a leading NOP is consumed and W1 stands alone
                    if (c0 == CLS_NONE) begin
                        take1 = (c1 != CLS_NONE);
                        pc_d  = pc_q + 32'd8;
                    end else begin
                        take0 = 1'b1;
                        if (c0 != CLS_J && c1 != CLS_NONE && c1 != c0) begin
                            take1 = 1'b1;
                            pc_d  = pc_q + 32'd8;
                        end else begin
                            pc_d  = pc_q + 32'd4;
                        end
                    end
                    n_iss   = {1'b0, take0} + {1'b0, take1};
                    isum    = {1'b0, issue_q} + {{(CNT_W-1){1'b0}}, n_iss};
                    issue_d = isum[CNT_W] ? '1 : isum[CNT_W-1:0];
                    dsum    = {1'b0, dual_q} + {{CNT_W{1'b0}}, 1'b1};
                    if (take0 && take1) begin
                        dual_d = dsum[CNT_W] ? '1 : dsum[CNT_W-1:0];
                    end
                end
            end
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_BOOT;
        endcase
    end

    always_comb begin
        type_i = (take0 && c0 == CLS_I) || (take1 && c1 == CLS_I);
        type_j = (take0 && c0 == CLS_J) || (take1 && c1 == CLS_J);
        type_r = (take0 && c0 == CLS_R) || (take1 && c1 == CLS_R);
        instruction_i = (take0 && c0 == CLS_I) ? imem.imem_rdata0 :
                        (take1 && c1 == CLS_I) ? imem.imem_rdata1 : 32'h0;
        instruction_j = (take0 && c0 == CLS_J) ? imem.imem_rdata0 :
                        (take1 && c1 == CLS_J) ? imem.imem_rdata1 : 32'h0;
        instruction_r = (take0 && c0 == CLS_R) ? imem.imem_rdata0 :
                        (take1 && c1 == CLS_R) ? imem.imem_rdata1 : 32'h0;
        program_counter = take0 ? pc_q + 32'd4 :
                          take1 ? pc_q + 32'd8 : 32'h0;
    end

    assign imem.imem_addr = pc_q;
    assign fetch_fault    = fault_q;
    assign issue_cnt      = issue_q;
    assign dual_cnt       = dual_q;

endmodule

// File: tb/tb_if_dual_fetch.sv
// Bench for if_dual_fetch: vector table plus fault/reset/saturation
// sequences, checked through an expected-value queue.
module tb_if_dual_fetch;

    localparam int CW = 4;

    localparam logic [31:0] LW    = 32'h8C22_0004;
    localparam logic [31:0] ADD   = 32'h0043_0820;
    localparam logic [31:0] ADDI1 = 32'h2001_0001;
    localparam logic [31:0] ADDI2 = 32'h2002_0002;
    localparam logic [31:0] JW    = 32'h0800_0040;
    localparam logic [31:0] JAL   = 32'h0C00_0010;

    typedef struct {
        logic        haz;
        logic        pcs;
        logic [31:0] bt;
        logic        jmp;
        logic [31:0] jt;
        logic        vld;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] addr;
        logic [2:0]  t;
        logic [31:0] ii;
        logic [31:0] ij;
        logic [31:0] ir;
        logic [31:0] pco;
        logic [CW-1:0] ic;
        logic [CW-1:0] dc;
        logic        flt;
    } vec_t;

    logic clk = 1'b0;
    logic btnc_i;
    logic hazard, PCSrc, jump;
    logic [31:0] branch_target, jump_target;
    logic type_i, type_j, type_r;
    logic [31:0] instruction_i, instruction_j, instruction_r;
    logic [31:0] program_counter;
    logic fetch_fault;
    logic [CW-1:0] issue_cnt, dual_cnt;

    int checks = 0;
    int errors = 0;
    int step = 0;
    vec_t sb[$];
    vec_t tbl[18];

    if_dual_fetch_if bus();

    if_dual_fetch #(.RESET_PC(32'h0), .CNT_W(CW)) dut (
        .clk(clk), .btnc_i(btnc_i), .hazard(hazard), .PCSrc(PCSrc),
        .branch_target(branch_target), .jump(jump),
        .jump_target(jump_target), .imem(bus),
        .type_i(type_i), .type_j(type_j), .type_r(type_r),
        .instruction_i(instruction_i), .instruction_j(instruction_j),
        .instruction_r(instruction_r), .program_counter(program_counter),
        .fetch_fault(fetch_fault), .issue_cnt(issue_cnt),
        .dual_cnt(dual_cnt)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(
        logic haz, logic pcs, logic [31:0] bt, logic jmp, logic [31:0] jt,
        logic vld, logic [31:0] w0, logic [31:0] w1, logic [31:0] addr,
        logic [2:0] t, logic [31:0] ii, logic [31:0] ij, logic [31:0] ir,
        logic [31:0] pco, logic [CW-1:0] ic, logic [CW-1:0] dc, logic flt);
        vec_t v;
        v.haz = haz; v.pcs = pcs; v.bt = bt; v.jmp = jmp; v.jt = jt;
        v.vld = vld; v.w0 = w0; v.w1 = w1; v.addr = addr; v.t = t;
        v.ii = ii; v.ij = ij; v.ir = ir; v.pco = pco;
        v.ic = ic; v.dc = dc; v.flt = flt;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step=%0d got=%h want=%h", nm, step, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        vec_t e;
        hazard = v.haz;
        PCSrc = v.pcs;
        branch_target = v.bt;
        jump = v.jmp;
        jump_target = v.jt;
        bus.imem_valid = v.vld;
        bus.imem_rdata0 = v.w0;
        bus.imem_rdata1 = v.w1;
        sb.push_back(v);
        #3;
        e = sb.pop_front();
        chk("imem_addr", bus.imem_addr, e.addr);
        chk("types", {29'h0, type_i, type_j, type_r}, {29'h0, e.t});
        chk("instr_i", instruction_i, e.ii);
        chk("instr_j", instruction_j, e.ij);
        chk("instr_r", instruction_r, e.ir);
        chk("prog_cnt", program_counter, e.pco);
        chk("issue_cnt", {28'h0, issue_cnt}, {28'h0, e.ic});
        chk("dual_cnt", {28'h0, dual_cnt}, {28'h0, e.dc});
        chk("fault", {31'h0, fetch_fault}, {31'h0, e.flt});
        step++;
    endtask

    task automatic cyc(input vec_t v);
        @(posedge clk);
        #1;
        apply(v);
    endtask

    initial begin
        tbl[0]  = mk(0,0,0,1,32'h10,1,LW,ADD,32'h0,3'b000,0,0,0,0,0,0,0);
        tbl[1]  = mk(0,0,0,0,0,1,LW,ADD,32'h10,3'b101,LW,0,ADD,32'h14,0,0,0);
        tbl[2]  = mk(0,0,0,0,0,1,ADDI1,ADDI2,32'h18,3'b100,ADDI1,0,0,32'h1C,2,1,0);
        tbl[3]  = mk(0,0,0,0,0,1,JW,ADD,32'h1C,3'b010,0,JW,0,32'h20,3,1,0);
        tbl[4]  = mk(1,0,0,0,0,0,LW,ADD,32'h20,3'b000,0,0,0,0,4,1,0);
        tbl[5]  = mk(1,0,0,0,0,0,LW,ADD,32'h20,3'b000,0,0,0,0,4,1,0);
        tbl[6]  = mk(1,0,0,0,0,0,LW,ADD,32'h20,3'b000,0,0,0,0,4,1,0);
        tbl[7]  = mk(0,0,0,0,0,0,LW,ADD,32'h20,3'b000,0,0,0,0,4,1,0);
        tbl[8]  = mk(1,0,0,0,0,1,LW,ADD,32'h20,3'b000,0,0,0,0,4,1,0);
        tbl[9]  = mk(0,0,0,0,0,1,0,JAL,32'h20,3'b010,0,JAL,0,32'h28,4,1,0);
        tbl[10] = mk(0,0,0,0,0,1,0,0,32'h28,3'b000,0,0,0,0,5,1,0);
        tbl[11] = mk(0,0,0,0,0,1,ADD,JAL,32'h30,3'b011,0,JAL,ADD,32'h34,5,1,0);
        tbl[12] = mk(0,0,0,0,0,1,ADD,0,32'h38,3'b001,0,0,ADD,32'h3C,7,2,0);
        tbl[13] = mk(0,1,32'h100,1,32'h200,1,LW,ADD,32'h3C,3'b000,0,0,0,0,8,2,0);
        tbl[14] = mk(0,0,0,0,0,1,ADDI1,JW,32'h100,3'b110,ADDI1,JW,0,32'h104,8,2,0);
        tbl[15] = mk(0,1,32'hFFFF_FFF8,0,0,1,LW,ADD,32'h108,3'b000,0,0,0,0,10,3,0);
        tbl[16] = mk(0,0,0,0,0,1,ADDI1,ADD,32'hFFFF_FFF8,3'b101,ADDI1,0,ADD,32'hFFFF_FFFC,10,3,0);
        tbl[17] = mk(0,0,0,0,0,0,LW,ADD,32'h0,3'b000,0,0,0,0,12,4,0);

        btnc_i = 1'b0;
        hazard = 0; PCSrc = 0; jump = 0;
        branch_target = 0; jump_target = 0;
        bus.imem_valid = 0; bus.imem_rdata0 = 0; bus.imem_rdata1 = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        btnc_i = 1'b1;
        apply(mk(0,0,0,0,0,1,ADDI1,ADD,32'h0,3'b000,0,0,0,0,0,0,0));

        for (int i = 0; i < 18; i++) cyc(tbl[i]);

        cyc(mk(0,0,0,1,32'h40,1,LW,ADD,32'h0,3'b000,0,0,0,0,12,4,0));
        cyc(mk(0,0,0,1,32'h202,1,LW,ADD,32'h40,3'b000,0,0,0,0,12,4,0));
        for (int i = 0; i < 10; i++)
            cyc(mk(0,i[0],32'h80,0,0,1,LW,ADD,32'h40,3'b000,0,0,0,0,12,4,1));

        @(posedge clk);
        #1;
        btnc_i = 1'b0;
        apply(mk(1,0,0,1,32'h300,1,LW,ADD,32'h40,3'b000,0,0,0,0,12,4,1));
        @(posedge clk);
        #1;
        btnc_i = 1'b1;
        apply(mk(0,0,0,0,0,1,ADDI1,ADD,32'h0,3'b000,0,0,0,0,0,0,0));

        for (int k = 0; k < 9; k++) begin
            logic [CW-1:0] ic;
            ic = (2 * k > 15) ? 4'hF : 4'(2 * k);
            cyc(mk(0,0,0,0,0,1,ADDI1,ADD,32'(8 * k),3'b101,ADDI1,0,ADD,
                   32'(8 * k + 4),ic,4'(k),0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
